// File: rtl/tone_pkg.sv
// Shared constants for the polyphonic tone bank: semitone half-period table
// (C4..B4 at 50 MHz) and the per-channel state encoding.
package tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HOLD = 2'd2
    } ch_state_t;

    localparam int unsigned HALF_TBL [12] = '{
        95556, 90194, 85131, 80353, 75843, 71586,
        67568, 63776, 60197, 56818, 53629, 50619
    };

    // Channels beyond the first twelve repeat the table one octave higher each time.
    function automatic int unsigned base_half(input int unsigned idx);
        return HALF_TBL[idx % 12] >> (idx / 12);
    endfunction

endpackage

// File: rtl/tone_channel.sv
// One tone channel: IDLE/PLAY/HOLD state machine, half-period counter and
// release (sustain) timer driving a single square-wave output.
module tone_channel
    import tone_pkg::*;
#(
    parameter int unsigned BASE_HALF   = 95556,
    parameter int          CNT_W       = 18,
    parameter int          OCT_W       = 2,
    parameter int unsigned SUSTAIN_CYC = 5_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ks,
    input  logic [OCT_W-1:0] oct,
    output logic             speaker,
    output logic             active
);

    localparam int               TMR_W    = (SUSTAIN_CYC > 1) ? $clog2(SUSTAIN_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = (SUSTAIN_CYC > 0) ? TMR_W'(SUSTAIN_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] BASE     = CNT_W'(BASE_HALF);
    localparam bit               HAS_SUST = (SUSTAIN_CYC > 0);

    ch_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] shifted, eff_half, step_cnt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic             spk, spk_nxt, step_spk, wrap;

    // The >= compare lets a mid-count octave raise wrap on the very next edge.
    always_comb begin
        shifted  = BASE >> oct;
        eff_half = (shifted == '0) ? CNT_W'(1) : shifted;
        wrap     = (cnt >= eff_half - CNT_W'(1));
        step_cnt = wrap ? '0 : cnt + CNT_W'(1);
        step_spk = spk ^ wrap;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        state_nxt = state;
        cnt_nxt   = cnt;
        spk_nxt   = spk;
        tmr_nxt   = tmr;
        unique case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                spk_nxt = 1'b0;
                if (ks) state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                cnt_nxt = step_cnt;
                spk_nxt = step_spk;
                if (!ks) begin
                    if (HAS_SUST) begin
                        state_nxt = ST_HOLD;
                        tmr_nxt   = TMR_LOAD;
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                        spk_nxt   = 1'b0;
                    end
                end
            end
            ST_HOLD: begin
                cnt_nxt = step_cnt;
                spk_nxt = step_spk;
                tmr_nxt = tmr - TMR_W'(1);
                if (ks) begin
                    state_nxt = ST_PLAY;
                end else if (tmr == '0) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    spk_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                spk_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            spk   <= 1'b0;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            spk   <= spk_nxt;
            tmr   <= tmr_nxt;
        end
    end

    assign speaker = spk;
    assign active  = (state != ST_IDLE);

endmodule

// File: rtl/tone_bank.sv
// Polyphonic square-wave tone bank: key synchroniser, N_KEYS tone channels,
// registered polyphony count and a first-order sigma-delta speaker bitstream.
module tone_bank
    import tone_pkg::*;
#(
    parameter int          N_KEYS      = 12,
    parameter int          CNT_W       = 18,
    parameter int          OCT_W       = 2,
    parameter int unsigned SUSTAIN_CYC = 5_000_000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_KEYS-1:0]             keys,
    input  logic [OCT_W-1:0]              oct,
    output logic [N_KEYS-1:0]             speaker,
    output logic [N_KEYS-1:0]             active,
    output logic [$clog2(N_KEYS+1)-1:0]   mix,
    output logic                          pdm_out
);

    localparam int               MIX_W = $clog2(N_KEYS + 1);
    localparam int               ACC_W = $clog2(2 * N_KEYS);
    localparam logic [ACC_W-1:0] N_ACC = ACC_W'(N_KEYS);

    logic [N_KEYS-1:0] sync_q [SYNC_STAGES];
    logic [N_KEYS-1:0] ks;
    logic [MIX_W-1:0]  pop;
    logic [ACC_W-1:0]  acc, sum;

    // Synchroniser flops are cleared too, so a held key replays cleanly after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= keys;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign ks = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        tone_channel #(
            .BASE_HALF   (base_half(i)),
            .CNT_W       (CNT_W),
            .OCT_W       (OCT_W),
            .SUSTAIN_CYC (SUSTAIN_CYC)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .ks      (ks[i]),
            .oct     (oct),
            .speaker (speaker[i]),
            .active  (active[i])
        );
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_KEYS; i++) pop = pop + MIX_W'(speaker[i]);
    end

    // acc stays below N_KEYS, so acc+mix never exceeds 2*N_KEYS-1.
    assign sum = acc + ACC_W'(mix);

    always_ff @(posedge clk) begin
        if (rst) begin
            mix     <= '0;
            acc     <= '0;
            pdm_out <= 1'b0;
        end else begin
            mix <= pop;
            if (sum >= N_ACC) begin
                acc     <= sum - N_ACC;
                pdm_out <= 1'b1;
            end else begin
                acc     <= sum;
                pdm_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tone_bank.sv
// Directed bench for tone_bank: waveform timing, octave wrap, sustain, reset,
// and a scoreboard for the speaker/mix/pdm pipeline.
module tb_tone_bank;

    localparam int OW  = 5;
    localparam int SUS = 1000;
    localparam int unsigned HALF [12] = '{
        95556, 90194, 85131, 80353, 75843, 71586,
        67568, 63776, 60197, 56818, 53629, 50619
    };

    typedef struct {
        logic [11:0] spk;
        logic [3:0]  mix;
        logic        pdm;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [11:0]   keys;
    logic [12:0]   keys13;
    logic [OW-1:0] oct;
    logic [11:0]   speaker, active;
    logic [3:0]    mix;
    logic          pdm_out;
    logic [12:0]   speaker13, active13;
    logic [3:0]    mix13;
    logic          pdm13;

    int   checks   = 0;
    int   failures = 0;
    int   e        = 0;
    exp_t sb [$];

    tone_bank #(.N_KEYS(12), .CNT_W(18), .OCT_W(OW), .SUSTAIN_CYC(SUS), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .keys    (keys),
        .oct     (oct),
        .speaker (speaker),
        .active  (active),
        .mix     (mix),
        .pdm_out (pdm_out)
    );

    tone_bank #(.N_KEYS(13), .CNT_W(18), .OCT_W(OW), .SUSTAIN_CYC(SUS), .SYNC_STAGES(2)) dut13 (
        .clk     (clk),
        .rst     (rst),
        .keys    (keys13),
        .oct     (oct),
        .speaker (speaker13),
        .active  (active13),
        .mix     (mix13),
        .pdm_out (pdm13)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic at_edge(input int target);
        while (e < target) tick();
    endtask

    function automatic int eh_of(input int idx, input int o);
        int b;
        b = int'(HALF[idx % 12] >> (idx / 12));
        b = b >> o;
        return (b == 0) ? 1 : b;
    endfunction

    // Speaker level k edges after entering PLAY with a fixed half-period.
    function automatic logic spk_at(input int k, input int eh);
        if (k < 0) return 1'b0;
        return ((k / eh) % 2) != 0;
    endfunction

    function automatic logic [11:0] pred_vec(input int k, input int o, input logic [11:0] pressed);
        logic [11:0] v;
        v = '0;
        for (int i = 0; i < 12; i++) v[i] = pressed[i] & spk_at(k, eh_of(i, o));
        return v;
    endfunction

    // Call on the edge where reset was last applied; keys already driven.
    task automatic run_sb(input int p, input int o, input logic [11:0] pressed, input int ncyc);
        logic [11:0] s_prev, s_cur;
        int          mix_m, acc_m, sum;
        exp_t        x, got;
        s_prev = '0;
        mix_m  = 0;
        acc_m  = 0;
        repeat (ncyc) begin
            s_cur = pred_vec(e + 1 - p, o, pressed);
            sum   = acc_m + mix_m;
            x.pdm = (sum >= 12);
            acc_m = x.pdm ? sum - 12 : sum;
            x.mix = 4'($countones(s_prev));
            x.spk = s_cur;
            mix_m  = int'(x.mix);
            s_prev = s_cur;
            sb.push_back(x);
            tick();
            got = sb.pop_front();
            check("sb_speaker", 32'(speaker), 32'(got.spk));
            check("sb_mix",     32'(mix),     32'(got.mix));
            check("sb_pdm",     32'(pdm_out), 32'(got.pdm));
        end
    endtask

    initial begin
        int t, p0, eh0, eh12, r, t2, p2, r1, h, t9, p9, eh9a, eh9b, ksw;
        logic base;
        int rr, pr;

        rst = 1'b1; keys = '0; keys13 = '0; oct = OW'(10);
        tick(); tick();
        check("rst_speaker", 32'(speaker), 0);
        check("rst_active",  32'(active),  0);
        check("rst_mix",     32'(mix),     0);
        check("rst_pdm",     32'(pdm_out), 0);
        check("rst_active13", 32'(active13), 0);
        rst = 1'b0;
        at_edge(4);

        // Key-to-PLAY latency and first-rise / period of channel 0 and C5 channel 12.
        eh0  = eh_of(0, 10);
        eh12 = eh_of(12, 10);
        t = e; keys[0] = 1'b1; keys13[12] = 1'b1;
        p0 = t + 3;
        at_edge(t + 2);
        check("lat_active0_early", 32'(active[0]), 0);
        for (int k = 0; k <= 4 * eh0 + 2; k++) begin
            at_edge(p0 + k);
            check("ch0_active",  32'(active[0]),    1);
            check("ch0_speaker", 32'(speaker[0]),   32'(spk_at(k, eh0)));
            check("ch12_speaker", 32'(speaker13[12]), 32'(spk_at(k, eh12)));
        end

        // Release: toggling continues for exactly SUS edges of tail, then silence.
        r = e; keys[0] = 1'b0;
        for (int x = r + 1; x <= r + 1005; x++) begin
            logic ea;
            at_edge(x);
            ea = (x < r + 3 + SUS);
            check("tail_active",  32'(active[0]),  32'(ea));
            check("tail_speaker", 32'(speaker[0]), 32'(ea ? spk_at(x - p0, eh0) : 1'b0));
        end

        // Re-press at hold edge 500: phase kept, channel never goes idle.
        t2 = e; keys[0] = 1'b1; p2 = t2 + 3;
        at_edge(p2 + 20);
        r1 = e; keys[0] = 1'b0; h = r1 + 3;
        at_edge(h + 497);
        keys[0] = 1'b1;
        for (int x = h + 498; x <= h + 1200; x++) begin
            at_edge(x);
            check("repress_active",  32'(active[0]),  1);
            check("repress_speaker", 32'(speaker[0]), 32'(spk_at(x - p2, eh0)));
        end

        // Octave raise mid-count: wrap on the next edge, then the shorter period.
        eh9a = eh_of(9, 10);
        eh9b = eh_of(9, 11);
        ksw  = 3 * eh9a - 10;
        t9 = e; keys[9] = 1'b1; p9 = t9 + 3;
        for (int k = 0; k <= ksw; k++) begin
            at_edge(p9 + k);
            check("ch9_speaker_oct10", 32'(speaker[9]), 32'(spk_at(k, eh9a)));
        end
        check("ch9_cnt_past_new_half", 32'((ksw % eh9a) >= eh9b - 1), 1);
        base = spk_at(ksw, eh9a);
        oct = OW'(11);
        for (int j = 0; j <= 3 * eh9b + 1; j++) begin
            at_edge(p9 + ksw + 1 + j);
            check("ch9_speaker_oct11", 32'(speaker[9]), 32'(base ^ 1'b1 ^ spk_at(j, eh9b)));
        end

        // Reset with five channels sounding; held keys replay from speaker=0.
        keys[3:1] = 3'b111;
        at_edge(e + 10);
        check("pre_rst_active_count", 32'($countones(active)), 5);
        rst = 1'b1;
        tick();
        check("midrst_speaker", 32'(speaker), 0);
        check("midrst_active",  32'(active),  0);
        check("midrst_mix",     32'(mix),     0);
        check("midrst_pdm",     32'(pdm_out), 0);
        check("midrst_speaker13", 32'(speaker13), 0);
        rst = 1'b0;
        rr = e; pr = rr + 3;
        at_edge(rr + 2);
        check("replay_active_early", 32'(active[0]), 0);
        for (int k = 0; k <= 2 * eh_of(0, 11) + 1; k++) begin
            at_edge(pr + k);
            check("replay_active0",  32'(active[0]),  1);
            check("replay_speaker0", 32'(speaker[0]), 32'(spk_at(k, eh_of(0, 11))));
            check("replay_speaker9", 32'(speaker[9]), 32'(spk_at(k, eh_of(9, 11))));
        end

        // All keys on one edge, mixed half-periods: mix/pdm scoreboard.
        keys = '0; oct = OW'(13); rst = 1'b1;
        tick();
        rst = 1'b0; keys = 12'hFFF;
        run_sb(e + 3, 13, 12'hFFF, 300);

        // All channels clamped to half-period 1 (toggle every clock, in phase).
        rst = 1'b1; oct = OW'(20);
        tick();
        rst = 1'b0;
        run_sb(e + 3, 20, 12'hFFF, 40);

        // Six channels toggling together.
        rst = 1'b1; keys = 12'h03F;
        tick();
        rst = 1'b0;
        run_sb(e + 3, 20, 12'h03F, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
